// File: rtl/draw_scheduler_if.sv
// Drawer and framebuffer bus shared by draw_scheduler.
// master = scheduler side, slave = drawers + framebuffer.
interface draw_scheduler_if #(
  parameter int NUM_CLIENTS = 3
);
  logic [NUM_CLIENTS-1:0]    client_start;
  logic [NUM_CLIENTS-1:0]    client_done;
  logic [NUM_CLIENTS*10-1:0] client_x;
  logic [NUM_CLIENTS*9-1:0]  client_y;
  logic [NUM_CLIENTS*4-1:0]  client_color;
  logic [9:0]                fb_x;
  logic [8:0]                fb_y;
  logic [3:0]                fb_color;
  logic                      fb_we;

  modport master (
    output client_start,
    input  client_done,
    input  client_x,
    input  client_y,
    input  client_color,
    output fb_x,
    output fb_y,
    output fb_color,
    output fb_we
  );

  modport slave (
    input  client_start,
    output client_done,
    output client_x,
    output client_y,
    output client_color,
    input  fb_x,
    input  fb_y,
    input  fb_color,
    input  fb_we
  );
endinterface

// File: rtl/draw_scheduler.sv
// Per-frame sequencer sharing one framebuffer write port
// among sprite drawers, serviced in fixed index order.
module draw_scheduler #(
  parameter int NUM_CLIENTS    = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [NUM_CLIENTS-1:0] enable,
  draw_scheduler_if.master       bus,
  output logic [1:0]             grant,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic [7:0]             missed_frames,
  output logic [NUM_CLIENTS-1:0] timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0] LAST = 2'(NUM_CLIENTS - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, START, GUARD, WAIT, DONE
  } state_t;

  state_t                 state, state_n;
  logic [1:0]             grant_n;
  logic [NUM_CLIENTS-1:0] en_q, en_n;
  logic [NUM_CLIENTS-1:0] to_n;
  logic [TW-1:0]          tcnt, tcnt_n;
  logic [7:0]             missed_n;
  logic [NUM_CLIENTS-1:0] start_v;
  logic                   we;
  logic                   last;
  logic                   done_g;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= '0;
      en_q          <= '0;
      tcnt          <= '0;
      timeout       <= '0;
      missed_frames <= '0;
    end else begin
      state         <= state_n;
      grant         <= grant_n;
      en_q          <= en_n;
      tcnt          <= tcnt_n;
      timeout       <= to_n;
      missed_frames <= missed_n;
    end
  end

  assign last    = (grant == LAST);
  assign done_g  = bus.client_done[grant];
  assign busy    = (state != IDLE);
  assign overrun = reset && frame_tick && busy;

  always_comb begin
    missed_n = missed_frames;
    if (overrun && missed_frames != 8'hFF)
      missed_n = missed_frames + 8'd1;
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    en_n       = en_q;
    tcnt_n     = tcnt;
    to_n       = timeout;
    start_v    = '0;
    we         = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_tick) begin
          en_n    = enable;
          grant_n = '0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (en_q[grant])
          state_n = START;
        else if (last)
          state_n = DONE;
        else
          grant_n = grant + 2'd1;
      end
      START: begin
        start_v[grant] = 1'b1;
        tcnt_n         = '0;
        state_n        = GUARD;
      end
      // drawer spends this cycle in its own start state
      GUARD: state_n = WAIT;
      WAIT: begin
        we = !done_g;
        if (done_g || tcnt == TMAX) begin
          if (!done_g)
            to_n[grant] = 1'b1;
          if (last) begin
            state_n = DONE;
          end else begin
            grant_n = grant + 2'd1;
            state_n = SCAN;
          end
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // gate to zero so idle drawer outputs never reach the bus
  always_comb begin
    bus.fb_x     = '0;
    bus.fb_y     = '0;
    bus.fb_color = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (we && grant == 2'(i)) begin
        bus.fb_x     = bus.client_x[i*10 +: 10];
        bus.fb_y     = bus.client_y[i*9 +: 9];
        bus.fb_color = bus.client_color[i*4 +: 4];
      end
    end
  end

  assign bus.fb_we        = we;
  assign bus.client_start = start_v;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with stub drawers
// and a start/frame_done scoreboard.
module tb_draw_scheduler;

  localparam int N   = 3;
  localparam int TO  = 16;
  localparam int LEN = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         frame_tick = 1'b0;
  logic [N-1:0] enable = '0;
  logic [1:0]   grant;
  logic         busy;
  logic         frame_done;
  logic         overrun;
  logic [7:0]   missed_frames;
  logic [N-1:0] timeout;

  draw_scheduler_if #(.NUM_CLIENTS(N)) bus();

  draw_scheduler #(
    .NUM_CLIENTS(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .frame_tick(frame_tick),
    .enable(enable),
    .bus(bus),
    .grant(grant),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun),
    .missed_frames(missed_frames),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // stub drawers: done rises LEN cycles after restart
  bit [7:0] scnt [N];
  bit       started [N];
  bit       stuck [N];

  always @(posedge clock)
    for (int i = 0; i < N; i++)
      if (bus.client_start[i]) begin
        scnt[i]    <= 8'd0;
        started[i] <= 1'b1;
      end else if (scnt[i] != 8'hFF) begin
        scnt[i] <= scnt[i] + 8'd1;
      end

  always_comb begin
    bus.client_done  = '0;
    bus.client_x     = '0;
    bus.client_y     = '0;
    bus.client_color = '0;
    for (int i = 0; i < N; i++) begin
      bus.client_done[i] = started[i] && !stuck[i]
                           && (scnt[i] >= 8'(LEN));
      bus.client_x[i*10 +: 10]    = 10'(100 + i);
      bus.client_y[i*9 +: 9]      = 9'(50 + i);
      bus.client_color[i*4 +: 4]  = 4'(5 + i);
    end
  end

  typedef struct {
    int client;
    int cyc;
  } ev_t;

  ev_t  start_q[$];
  int   done_q[$];
  int   wr[N];
  ev_t  e;
  int   dc;

  always @(negedge clock) if (reset) begin
    if (bus.client_start != '0) begin
      if (start_q.size() == 0) begin
        check("start_unexpected", 32'(bus.client_start), 0);
      end else begin
        e = start_q.pop_front();
        check("start_onehot", 32'(bus.client_start),
              32'(1) << e.client);
        check("start_cycle", cyc, e.cyc);
      end
    end
    if (frame_done) begin
      if (done_q.size() == 0) begin
        check("frame_done_unexpected", 1, 0);
      end else begin
        dc = done_q.pop_front();
        check("frame_done_cycle", cyc, dc);
      end
    end
    if (bus.fb_we) begin
      wr[grant]++;
      check("fb_color", 32'(bus.fb_color), 5 + grant);
      check("fb_xy", {bus.fb_x, bus.fb_y},
            {10'(100 + grant), 9'(50 + grant)});
    end else begin
      check("fb_gated",
            {bus.fb_x, bus.fb_y, bus.fb_color}, 0);
    end
  end

  // reference timing: returns the DONE cycle of the pass
  function automatic int plan(input int t0,
                              input logic [N-1:0] en);
    int t = t0 + 1;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        start_q.push_back('{i, t + 1});
        t += 3 + (stuck[i] ? TO : LEN);
      end else begin
        t += 1;
      end
    end
    done_q.push_back(t);
    return t;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int td, input string tag);
    for (int k = 0; k < 1000 && cyc <= td; k++) step();
    check({tag, "_done_pending"}, done_q.size(), 0);
    check({tag, "_start_pending"}, start_q.size(), 0);
  endtask

  task automatic run_pass(input logic [N-1:0] en,
                          input string tag);
    int w0 [N];
    int td;
    w0 = wr;
    step();
    enable     = en;
    frame_tick = 1'b1;
    td = plan(cyc, en);
    step();
    frame_tick = 1'b0;
    enable     = ~en;
    wait_done(td, tag);
    for (int i = 0; i < N; i++)
      check({tag, "_writes"}, wr[i] - w0[i],
            en[i] ? (stuck[i] ? TO : LEN - 1) : 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_start"}, 32'(bus.client_start), 0);
    check({tag, "_fb"}, {bus.fb_we, bus.fb_x,
          bus.fb_y, bus.fb_color}, 0);
    check({tag, "_flags"},
          {busy, frame_done, overrun, grant}, 0);
    check({tag, "_missed"}, 32'(missed_frames), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    int t;
    int td;
    int last_done;

    frame_tick = 1'b1;
    enable     = '1;
    repeat (2) begin
      step();
      check_idle("reset");
    end
    step();
    frame_tick = 1'b0;
    reset      = 1'b1;

    run_pass(3'b111, "full");
    run_pass(3'b010, "sparse");

    stuck[2] = 1'b1;
    run_pass(3'b111, "stuck");
    check("stuck_timeout", 32'(timeout), 32'b100);
    stuck[2] = 1'b0;
    run_pass(3'b111, "after_stuck");
    check("sticky_timeout", 32'(timeout), 32'b100);

    step();
    enable     = 3'b001;
    frame_tick = 1'b1;
    td = plan(cyc, 3'b001);
    step();
    frame_tick = 1'b0;
    repeat (3) step();
    frame_tick = 1'b1;
    @(negedge clock);
    check("overrun_pulse", {overrun, busy}, 2'b11);
    step();
    frame_tick = 1'b0;
    #1;
    check("overrun_low", 32'(overrun), 0);
    check("missed_one", 32'(missed_frames), 1);
    wait_done(td, "overrun");

    for (int i = 0; i < N; i++) stuck[i] = 1'b1;
    step();
    enable     = '1;
    frame_tick = 1'b1;
    t = cyc;
    last_done = t;
    for (int p = 0; p < 6; p++) begin
      last_done = plan(t, 3'b111);
      t = last_done + 1;
    end
    for (int k = 0; k < 1000 && cyc < last_done; k++) step();
    step();
    frame_tick = 1'b0;
    wait_done(last_done, "saturate");
    check("missed_sat", 32'(missed_frames), 255);
    check("all_timeout", 32'(timeout), 32'b111);
    for (int i = 0; i < N; i++) stuck[i] = 1'b0;

    step();
    enable     = '1;
    frame_tick = 1'b1;
    td = plan(cyc, 3'b111);
    step();
    frame_tick = 1'b0;
    for (int k = 0; k < 100 && cyc < td - 12; k++) step();
    check("mid_grant", 32'(grant), 1);
    reset = 1'b0;
    step();
    check_idle("mid_reset");
    start_q.delete();
    done_q.delete();
    reset = 1'b1;
    run_pass(3'b111, "restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Per-frame sequencer that shares the single framebuffer write port among the sprite drawers (player, laser, enemy). On each frame tick it starts each enabled drawer in fixed index order. It forwards that drawer's pixel stream to the framebuffer while the drawer is drawing, then moves to the next drawer. It sits between the frame-timing logic and the framebuffer/VGA buffer, and drives each drawer's restart (`reset`) input.

## Interface
Parameters:
- NUM_CLIENTS, 3, number of drawers; index 0 = player, 1 = laser, 2 = enemy.
- TIMEOUT_CYCLES, 4096, maximum WAIT cycles allowed per client before it is abandoned.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse requesting a redraw pass.
- enable  in  NUM_CLIENTS  per-client draw enable; sampled on an accepted tick.
- client_start  out  NUM_CLIENTS  one-hot, one-cycle restart pulse to the drawer (wired to its `reset`).
- client_done  in  NUM_CLIENTS  drawer `done` levels.
- client_x  in  NUM_CLIENTS*10  packed drawer x outputs; client i in bits [10i+9:10i].
- client_y  in  NUM_CLIENTS*9  packed drawer y outputs.
- client_color  in  NUM_CLIENTS*4  packed drawer color indices.
- fb_x  out  10, fb_y  out  9, fb_color  out  4  framebuffer write address and data.
- fb_we  out  1  framebuffer write enable.
- grant  out  2  index of the client being serviced.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of a pass.
- overrun  out  1  one-cycle pulse when a tick is dropped.
- missed_frames  out  8  saturating count of dropped ticks.
- timeout  out  NUM_CLIENTS  sticky per-client timeout flags.

## Operation
- States: IDLE, SCAN, START, GUARD, WAIT, DONE.
- IDLE:
  - On frame_tick: latch enable into enable_q, set grant to 0, go to SCAN.
- SCAN:
  - If enable_q[grant] is set: go to START.
  - Else if grant == NUM_CLIENTS-1: go to DONE.
  - Else: increment grant and stay in SCAN (one client examined per cycle).
- START:
  - client_start[grant] = 1 for this cycle only.
  - Clear the timeout counter.
  - Go to GUARD.
- GUARD:
  - client_done is ignored; this cycle is the drawer's own start state.
  - fb_we = 0.
  - Go to WAIT.
- WAIT:
  - fb_we = !client_done[grant].
  - Timeout counter increments each cycle.
  - Exit when client_done[grant] is seen, or when the counter reaches TIMEOUT_CYCLES-1; on the timeout exit, set timeout[grant].
  - On exit: if grant == NUM_CLIENTS-1, go to DONE; else increment grant and go to SCAN.
- DONE:
  - frame_done = 1 for this cycle.
  - Go to IDLE.
- Datapath:
  - fb_x, fb_y and fb_color are a combinational mux of the granted client's fields, gated to 0 whenever fb_we = 0. This keeps undriven (Z) drawer outputs off the bus.
- Tick during a pass:
  - A frame_tick while not in IDLE is dropped.
  - overrun pulses in the same cycle.
  - missed_frames increments, saturating at 255.
  - The current pass continues unaffected.
- enable changes during a pass have no effect until the next accepted tick.
- Timeout counter is 12 bits, sized to hold TIMEOUT_CYCLES-1.
- grant never exceeds NUM_CLIENTS-1.

## Timing
- Reset (reset = 0 at a rising edge):
  - State goes to IDLE and grant to 0.
  - client_start, fb_we, fb_x, fb_y, fb_color, busy, frame_done, overrun all 0.
  - missed_frames and timeout cleared.
  - Takes effect on the edge at which reset = 0 is sampled, including mid-pass.
  - No client_start pulse is issued during or after reset until the next tick.
- Latency with the tick sampled at cycle 0:
  - SCAN in cycle 1.
  - START in cycle 2 if client 0 is enabled.
  - GUARD in cycle 3.
  - First possible fb_we in cycle 4.
- Per enabled client: 1 SCAN + 1 START + 1 GUARD + N WAIT cycles, where N includes the cycle in which done is seen.
- Each disabled client costs 1 SCAN cycle.
- DONE adds 1 cycle. IDLE accepts a new tick on the cycle after DONE.
- In WAIT, the cycle in which client_done is first seen has fb_we = 0.
- Reaching the timeout threshold and seeing done in the same cycle is treated as done; timeout is not set.

## Test plan
- Reset: hold reset = 0 for 2 cycles with frame_tick = 1 -> every output 0, busy = 0, no client_start pulse.
- Full pass:
  - Stimulus: enable = 3'b111; stub drawers hold done = 0 for the 4 cycles after GUARD, then done = 1.
  - Required: client_start pulses at cycles 2, 10, 18; fb_we high for exactly 12 cycles; fb_color matches the granted stub; frame_done at cycle 25.
- Sparse enable: enable = 3'b010 -> only client_start[1] pulses, at cycle 3; grant = 1 during WAIT; clients 0 and 2 never write.
- Stuck client:
  - Stimulus: TIMEOUT_CYCLES = 16; client 2 never asserts done.
  - Required: timeout = 3'b100 after 16 WAIT cycles; fb_we drops; frame_done still pulses; the flag survives the next pass.
- Overrun: frame_tick pulsed in WAIT -> overrun pulses in that cycle, missed_frames = 1, no restart. After 300 dropped ticks, missed_frames = 255.
- Reset mid-pass: reset = 0 during client 1's WAIT -> next cycle IDLE, fb_we = 0, grant = 0, timeout = 0; the following tick restarts from client 0.
